// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: pulls words from a TX FIFO and serialises them as
// start + DATA_WIDTH data bits (LSB first) + stop, relaunching with no idle gap.
module uart_tx_scheduler #(
  parameter int CLKS_PER_BAUD = 868,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_w,
  input  logic                  i_enable_w,
  input  logic                  i_cts_n_w,
  input  logic [DATA_WIDTH-1:0] i_fifo_data_w,
  input  logic                  i_fifo_empty_w,
  output logic                  o_fifo_read_w,
  output logic                  o_tx_w,
  output logic                  o_busy_w,
  output logic                  o_done_w
);

  localparam int CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BAUD - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BAUD - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state_q = S_IDLE;
  logic [CW-1:0]         baud_q  = '0;
  logic [BW-1:0]         bit_q   = '0;
  logic [DATA_WIDTH-1:0] shreg_q = '0;
  logic                  tx_q    = 1'b1;
  logic                  busy_q  = 1'b0;
  logic                  done_q  = 1'b0;

  logic baud_last_s;
  logic launch_s;

  assign baud_last_s = (baud_q == BAUD_LAST);

  // Launch is decided combinationally so the FIFO read lands in the same cycle
  // as the decision; reset masks it so an aborted or held block never pops.
  assign launch_s = i_enable_w & ~i_cts_n_w & ~i_fifo_empty_w & ~i_reset_w &
                    ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_last_s));

  assign o_fifo_read_w = launch_s;
  assign o_tx_w        = tx_q;
  assign o_busy_w      = busy_q;
  assign o_done_w      = done_q;

  always_ff @(posedge i_clk) begin
    if (i_reset_w) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch_s) begin
            shreg_q <= i_fifo_data_w;
            baud_q  <= '0;
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last_s) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_last_s) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + BW'(1);
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        S_STOP: begin
          // done is registered one cycle early so it is high in the final stop cycle
          done_q <= (baud_q == BAUD_PRE);
          if (baud_last_s) begin
            baud_q <= '0;
            if (launch_s) begin
              shreg_q <= i_fifo_data_w;
              state_q <= S_START;
              tx_q    <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (CLKS_PER_BAUD=4, DATA_WIDTH=8): records a
// per-cycle trace of the outputs and checks it against hand-derived frame timing.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       cts_n = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_read, tx, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] fifo_q[$];
  logic scramble = 1'b0;

  logic tr_rd   [0:2047];
  logic tr_tx   [0:2047];
  logic tr_busy [0:2047];
  logic tr_done [0:2047];

  uart_tx_scheduler #(.CLKS_PER_BAUD(4), .DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_reset_w(reset), .i_enable_w(enable), .i_cts_n_w(cts_n),
    .i_fifo_data_w(fifo_data), .i_fifo_empty_w(fifo_empty),
    .o_fifo_read_w(fifo_read), .o_tx_w(tx), .o_busy_w(busy), .o_done_w(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    if (scramble) fifo_data = 8'(cyc * 37 + 11);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // One clock: record this cycle's outputs, advance, pop the FIFO model on a read.
  task automatic tick();
    logic rd_s;
    #1;
    tr_rd[cyc]   = fifo_read;
    tr_tx[cyc]   = tx;
    tr_busy[cyc] = busy;
    tr_done[cyc] = done;
    rd_s = fifo_read;
    @(posedge clk);
    #1;
    if (rd_s) begin
      if (fifo_q.size() == 0) chk("read_when_empty", 32'd1, 32'd0);
      else void'(fifo_q.pop_front());
    end
    cyc++;
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int cnt(input int sel, input int a, input int b);
    int c = 0;
    for (int i = a; i < b; i++) begin
      case (sel)
        0: c += int'(tr_rd[i]);
        1: c += int'(tr_tx[i] == 1'b0);
        2: c += int'(tr_busy[i]);
        default: c += int'(tr_done[i]);
      endcase
    end
    return c;
  endfunction

  // Frame launched at cycle r: bit k (start, data LSB first, stop) held on r+1+4k..r+4+4k.
  task automatic check_frame(input string tag, input int r, input logic [7:0] b);
    logic [9:0] fr;
    logic [3:0] got;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      got = {tr_tx[r+4+4*k], tr_tx[r+3+4*k], tr_tx[r+2+4*k], tr_tx[r+1+4*k]};
      chk($sformatf("%s_bit%0d", tag, k), {28'd0, got}, {28'd0, {4{fr[k]}}});
    end
    chk($sformatf("%s_done", tag), {31'd0, tr_done[r+40]}, 32'd1);
  endtask

  int r, x;

  initial begin
    #1;
    chk("pwrup_tx", {31'd0, tx}, 32'd1);
    chk("pwrup_busy", {31'd0, busy}, 32'd0);
    chk("pwrup_done", {31'd0, done}, 32'd0);
    chk("pwrup_rd", {31'd0, fifo_read}, 32'd0);

    reset = 1'b1;
    run(2);
    reset = 1'b0;
    tick();
    chk("rst_tx", {31'd0, tr_tx[cyc-1]}, 32'd1);
    chk("rst_busy", {31'd0, tr_busy[cyc-1]}, 32'd0);

    // single byte 0xA5
    enable = 1'b1; cts_n = 1'b0;
    push(8'hA5);
    r = cyc;
    run(50);
    chk("single_rd_at", {31'd0, tr_rd[r]}, 32'd1);
    chk("single_rd_cnt", cnt(0, r, r+50), 32'd1);
    check_frame("single", r, 8'hA5);
    chk("single_done_cnt", cnt(3, r, r+50), 32'd1);
    chk("single_busy_cnt", cnt(2, r, r+50), 32'd40);
    chk("single_idle_tx", {31'd0, tr_tx[r+41]}, 32'd1);

    // back-to-back 0x00, 0xFF, 0x3C
    push(8'h00); push(8'hFF); push(8'h3C);
    r = cyc;
    run(140);
    chk("b2b_rd_cnt", cnt(0, r, r+140), 32'd3);
    chk("b2b_rd0", {31'd0, tr_rd[r]}, 32'd1);
    chk("b2b_rd1", {31'd0, tr_rd[r+40]}, 32'd1);
    chk("b2b_rd2", {31'd0, tr_rd[r+80]}, 32'd1);
    check_frame("b2b0", r, 8'h00);
    check_frame("b2b1", r+40, 8'hFF);
    check_frame("b2b2", r+80, 8'h3C);
    chk("b2b_busy_cnt", cnt(2, r+1, r+121), 32'd120);
    chk("b2b_busy_end", {31'd0, tr_busy[r+121]}, 32'd0);

    // empty FIFO with enable, then pending byte with enable low
    r = cyc;
    run(100);
    chk("empty_rd", cnt(0, r, r+100), 32'd0);
    chk("empty_tx_low", cnt(1, r, r+100), 32'd0);
    chk("empty_busy", cnt(2, r, r+100), 32'd0);
    enable = 1'b0;
    push(8'hC3);
    r = cyc;
    run(100);
    chk("dis_rd", cnt(0, r, r+100), 32'd0);
    chk("dis_tx_low", cnt(1, r, r+100), 32'd0);
    chk("dis_busy", cnt(2, r, r+100), 32'd0);

    // flow control: held off by cts_n, launch on its fall, cts_n rising mid-frame
    enable = 1'b1; cts_n = 1'b1;
    r = cyc;
    run(20);
    chk("cts_hold_rd", cnt(0, r, r+20), 32'd0);
    chk("cts_hold_busy", cnt(2, r, r+20), 32'd0);
    cts_n = 1'b0;
    r = cyc;
    tick();
    chk("cts_fall_rd", {31'd0, tr_rd[r]}, 32'd1);
    run(9);
    cts_n = 1'b1;
    push(8'h00);
    run(40);
    check_frame("cts", r, 8'hC3);
    chk("cts_rd_cnt", cnt(0, r, r+50), 32'd1);
    chk("cts_busy_end", {31'd0, tr_busy[r+41]}, 32'd0);

    // reset during data bit 3 of a 0x00 frame
    push(8'h96);
    cts_n = 1'b0;
    r = cyc;
    run(18);
    reset = 1'b1;
    x = cyc;
    tick();
    reset = 1'b0;
    run(45);
    chk("rstmid_launch", {31'd0, tr_rd[r]}, 32'd1);
    chk("rstmid_bit3_tx", {31'd0, tr_tx[x]}, 32'd0);
    chk("rstmid_rd_in_rst", {31'd0, tr_rd[x]}, 32'd0);
    chk("rstmid_tx_after", {31'd0, tr_tx[x+1]}, 32'd1);
    chk("rstmid_busy_after", {31'd0, tr_busy[x+1]}, 32'd0);
    chk("rstmid_no_done", cnt(3, r, x+2), 32'd0);
    chk("rstmid_relaunch", {31'd0, tr_rd[x+1]}, 32'd1);
    check_frame("rstmid_new", x+1, 8'h96);

    // data hold: FIFO data scrambled every cycle after launch
    push(8'h6B);
    r = cyc;
    tick();
    enable = 1'b0;
    scramble = 1'b1;
    refresh();
    run(45);
    scramble = 1'b0;
    refresh();
    chk("hold_rd_cnt", cnt(0, r, r+46), 32'd1);
    check_frame("hold", r, 8'h6B);

    // reset wins over a simultaneous launch condition
    enable = 1'b1;
    reset = 1'b1;
    push(8'h11);
    x = cyc;
    run(2);
    reset = 1'b0;
    run(45);
    chk("prio_rd0", {31'd0, tr_rd[x]}, 32'd0);
    chk("prio_rd1", {31'd0, tr_rd[x+1]}, 32'd0);
    chk("prio_busy", {31'd0, tr_busy[x+1]}, 32'd0);
    chk("prio_launch", {31'd0, tr_rd[x+2]}, 32'd1);
    check_frame("prio", x+2, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
